// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS-32 core: opcodes, functs, ALU
// controls, datapath mux selects and the sequencer state set.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RTWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
  } state_e;

endpackage

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU control; unknown functs fall back to ADD and flag illegal.
module mc_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS-32 datapath, with a retired-
// instruction counter. Outputs decode the registered state and are held low in reset.
module mc_control_fsm
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_opcode,
  input  logic [5:0]       i_funct,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_dst,
  output logic             o_mem_to_reg,
  output logic             o_reg_write,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_pc_src,
  output logic [3:0]       o_alu_control,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instr_count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       fn_alu;
  logic             fn_illegal;
  logic             op_legal;
  logic             retire;

  mc_alu_decode u_alu_decode (
    .funct       (i_funct),
    .alu_control (fn_alu),
    .illegal     (fn_illegal)
  );

  always_comb begin
    case (i_opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = i_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = fn_illegal ? S_FETCH : S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Last cycle of every completed instruction; illegal paths never land here.
  always_comb begin
    case (state_q)
      S_MEMWB, S_RTWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
      S_MEMWR:                                     retire = i_mem_ready;
      default:                                     retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    o_pc_en       = 1'b0;
    o_iord        = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_ir_write    = 1'b0;
    o_reg_dst     = 1'b0;
    o_mem_to_reg  = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = SRCB_B;
    o_pc_src      = PCSRC_ALU;
    o_alu_control = 4'b0000;
    o_illegal     = 1'b0;
    if (!i_rst) begin
      case (state_q)
        S_FETCH: begin
          o_mem_read    = 1'b1;
          o_alu_src_b   = SRCB_FOUR;
          o_alu_control = ALU_ADD;
          o_ir_write    = i_mem_ready;
          o_pc_en       = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_b   = SRCB_IMM_SH2;
          o_alu_control = ALU_ADD;
          o_illegal     = !op_legal;
        end
        S_MEMADR, S_ADDIEX: begin
          o_alu_src_a   = 1'b1;
          o_alu_src_b   = SRCB_IMM;
          o_alu_control = ALU_ADD;
        end
        S_MEMRD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        S_MEMWB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        S_EXEC: begin
          o_alu_src_a   = 1'b1;
          o_alu_control = fn_alu;
          o_illegal     = fn_illegal;
        end
        S_RTWB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          o_alu_src_a   = 1'b1;
          o_alu_control = ALU_SUB;
          o_pc_src      = PCSRC_ALUOUT;
          o_pc_en       = i_zero;
        end
        S_ADDIWB: o_reg_write = 1'b1;
        S_JUMP: begin
          o_pc_src = PCSRC_JUMP;
          o_pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_instr_count = i_rst ? '0 : cnt_q;

endmodule
